// File: rtl/stream_mux_rr_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//   Shared constants and helpers for the stream_mux_rr block.
//   MODE_RR    : round-robin arbitration (rotating search start).
//   MODE_PRIO  : fixed priority, lowest channel index wins.
//   clog2_min1 : channel-index width, never narrower than one bit.
// ---------------------------------------------------------------------------
package mux_pkg;

   localparam int MODE_RR   = 0;
   localparam int MODE_PRIO = 1;

   // Index width for n channels; n=1 and n=2 both need a single bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin / fixed-priority arbiter with its own search pointer.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     req[N]       : per-channel request
//     advance      : a grant was consumed this cycle; rotate the pointer
//     grant[N]     : one-hot grant (all zero when nothing requests)
//     grant_idx    : binary index of the granted channel
//     grant_valid  : at least one channel requests
// ---------------------------------------------------------------------------
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N     = 4,
   parameter int MODE  = MODE_RR,
   parameter int SEL_W = clog2_min1(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx,
   output logic             grant_valid
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] ptr_next;

   // The circular search ptr..N-1,0..ptr-1 is split into two linear passes:
   // first the channels at or above ptr, then wrap to the bottom. In fixed
   // priority mode the first pass covers every channel, starting at 0.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!grant_valid && req[i] && (MODE == MODE_PRIO || i >= 32'(ptr))) begin
            grant       = '0;
            grant[i]    = 1'b1;
            grant_idx   = SEL_W'(i);
            grant_valid = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!grant_valid && req[i]) begin
            grant       = '0;
            grant[i]    = 1'b1;
            grant_idx   = SEL_W'(i);
            grant_valid = 1'b1;
         end
      end
   end

   // Next search start is the channel after the winner, wrapping at N-1.
   always_comb begin
      if (grant_idx == SEL_W'(N - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = grant_idx + SEL_W'(1);
      end
   end

   // Pointer only moves on a real transfer; idle cycles leave it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (MODE == MODE_RR && advance && grant_valid) begin
         ptr <= ptr_next;
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
//   N-channel valid/ready stream multiplexer with round-robin (MODE=0) or
//   fixed-priority (MODE=1) arbitration and a registered output stage.
//   Ports:
//     clk        : clock, rising edge
//     rst        : asynchronous active-high reset
//     in_valid   : per-channel valid
//     in_data    : channel i at bits [i*WIDTH +: WIDTH]
//     in_ready   : per-channel ready, one-hot or zero (combinational)
//     out_valid  : output register holds a beat
//     out_data   : registered data
//     out_sel    : channel that sourced out_data
//     out_ready  : consumer accepts the current beat
// ---------------------------------------------------------------------------
module stream_mux_rr
   import mux_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int N     = 4,
   parameter int SEL_W = clog2_min1(N),
   parameter int MODE  = MODE_RR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_sel,
   input  logic               out_ready
);

   logic             load;
   logic             xfer;
   logic [N-1:0]     grant;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_valid;
   logic [WIDTH-1:0] sel_data;

   // Output register may be (re)loaded when empty or being drained this cycle.
   assign load = !out_valid || out_ready;

   // rst gating keeps ready low during reset even though out_valid=0 then
   // makes load true.
   assign in_ready = (load && !rst) ? grant : '0;
   assign xfer     = load && grant_valid && !rst;

   rr_arbiter #(
      .N     (N),
      .MODE  (MODE),
      .SEL_W (SEL_W)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (in_valid),
      .advance     (xfer),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // AND-OR select driven by the one-hot grant.
   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant[i]) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Data and index hold when the register empties, only valid drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (load) begin
         if (grant_valid) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_rr
//   Bench for stream_mux_rr with one round-robin and one fixed-priority
//   instance sharing stimulus. Expected beats are queued as they are driven
//   and compared when the consumer side accepts them.
// ---------------------------------------------------------------------------
module tb_stream_mux_rr;

   localparam int N     = 4;
   localparam int WIDTH = 64;
   localparam int SEL_W = 2;

   typedef struct {
      logic [SEL_W-1:0] sel;
      logic [WIDTH-1:0] data;
   } beat_t;

   logic               clk = 1'b0;
   logic               rst;
   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic               out_ready;
   logic               use_prio;

   logic [N-1:0]       rr_in_ready,  pr_in_ready;
   logic               rr_out_valid, pr_out_valid;
   logic [WIDTH-1:0]   rr_out_data,  pr_out_data;
   logic [SEL_W-1:0]   rr_out_sel,   pr_out_sel;

   logic [N-1:0]       s_in_ready;
   logic               s_out_valid;
   logic [WIDTH-1:0]   s_out_data;
   logic [SEL_W-1:0]   s_out_sel;

   beat_t sb_q[$];
   int    checks   = 0;
   int    failures = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .MODE(0)) dut_rr (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (rr_in_ready),
      .out_valid (rr_out_valid),
      .out_data  (rr_out_data),
      .out_sel   (rr_out_sel),
      .out_ready (out_ready)
   );

   stream_mux_rr #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .MODE(1)) dut_pr (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (pr_in_ready),
      .out_valid (pr_out_valid),
      .out_data  (pr_out_data),
      .out_sel   (pr_out_sel),
      .out_ready (out_ready)
   );

   assign s_in_ready  = use_prio ? pr_in_ready  : rr_in_ready;
   assign s_out_valid = use_prio ? pr_out_valid : rr_out_valid;
   assign s_out_data  = use_prio ? pr_out_data  : rr_out_data;
   assign s_out_sel   = use_prio ? pr_out_sel   : rr_out_sel;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int sel, input logic [63:0] data);
      beat_t b;
      b.sel  = SEL_W'(sel);
      b.data = data;
      sb_q.push_back(b);
   endtask

   task automatic set_data(input int ch, input logic [63:0] d);
      in_data[ch*WIDTH +: WIDTH] = d;
   endtask

   // Drive one cycle's inputs at the falling edge, then check the
   // combinational ready vector before the next rising edge.
   task automatic drive(input logic [3:0] v, input logic r, input logic [3:0] exp_ready,
                        input string tag);
      @(negedge clk);
      in_valid  = v;
      out_ready = r;
      #1;
      check(tag, 64'(s_in_ready), 64'(exp_ready));
   endtask

   // Consumer side: a beat leaves when out_valid && out_ready at the edge.
   always @(posedge clk) begin : monitor
      beat_t b;
      if (!rst && s_out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_beat", 64'(1), 64'(0));
         end else begin
            b = sb_q.pop_front();
            check("sb_sel",  64'(s_out_sel), 64'(b.sel));
            check("sb_data", s_out_data, b.data);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin : stim
      logic [3:0] exp_r;
      rst       = 1'b1;
      use_prio  = 1'b0;
      in_valid  = '0;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) set_data(i, 64'hA0 + 64'(i));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out_valid", 64'(s_out_valid), 64'(0));
      check("reset_out_data",  s_out_data, 64'(0));
      check("reset_out_sel",   64'(s_out_sel), 64'(0));
      check("reset_in_ready",  64'(s_in_ready), 64'(0));

      // Round-robin over all four channels, two full rotations.
      for (int k = 0; k < 8; k++) begin
         exp_r = 4'b0001 << (k % 4);
         drive(4'b1111, 1'b1, exp_r, "rr_ready");
         push(k % 4, 64'hA0 + 64'(k % 4));
      end
      drive(4'b0000, 1'b1, 4'b0000, "rr_drain_ready");

      // Steer ptr to 2 via a channel-1 transfer, then 1/3 alternate.
      drive(4'b0010, 1'b1, 4'b0010, "sparse_setup");
      push(1, 64'hA1);
      drive(4'b1010, 1'b1, 4'b1000, "sparse_g3a");
      push(3, 64'hA3);
      drive(4'b1010, 1'b1, 4'b0010, "sparse_g1");
      push(1, 64'hA1);
      drive(4'b1010, 1'b1, 4'b1000, "sparse_g3b");
      push(3, 64'hA3);
      drive(4'b0000, 1'b1, 4'b0000, "sparse_drain");

      // Backpressure: beat 0x55 from channel 2 held for three cycles.
      set_data(2, 64'h55);
      drive(4'b0100, 1'b1, 4'b0100, "bp_load");
      push(2, 64'h55);
      for (int k = 0; k < 3; k++) begin
         drive(4'b1111, 1'b0, 4'b0000, "bp_hold_ready");
         @(posedge clk);
         #1;
         check("bp_hold_valid", 64'(s_out_valid), 64'(1));
         check("bp_hold_data",  s_out_data, 64'h55);
         check("bp_hold_sel",   64'(s_out_sel), 64'(2));
      end
      drive(4'b1111, 1'b1, 4'b1000, "bp_release_ready");
      push(3, 64'hA3);
      @(posedge clk);
      #1;
      check("bp_same_edge_data", s_out_data, 64'hA3);
      check("bp_same_edge_sel",  64'(s_out_sel), 64'(3));
      set_data(2, 64'hA2);
      drive(4'b0000, 1'b1, 4'b0000, "bp_drain");

      // Idle drain: one beat, then empty cycles must not move ptr.
      set_data(0, 64'hDEAD_BEEF);
      drive(4'b0001, 1'b1, 4'b0001, "idle_load");
      push(0, 64'hDEAD_BEEF);
      @(posedge clk);
      #1;
      check("idle_beat_valid", 64'(s_out_valid), 64'(1));
      for (int k = 0; k < 3; k++) begin
         drive(4'b0000, 1'b1, 4'b0000, "idle_ready");
         @(posedge clk);
         #1;
         check("idle_valid", 64'(s_out_valid), 64'(0));
         check("idle_data",  s_out_data, 64'hDEAD_BEEF);
      end
      drive(4'b1111, 1'b1, 4'b0010, "idle_ptr_kept");
      push(1, 64'hA1);
      set_data(0, 64'hA0);
      drive(4'b0000, 1'b1, 4'b0000, "idle_drain");

      // Reset mid-stream: pending beat discarded, ptr back to 0.
      drive(4'b1111, 1'b0, 4'b0100, "rst_pre_ready");
      @(posedge clk);
      #1;
      check("rst_pre_valid", 64'(s_out_valid), 64'(1));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_async_valid", 64'(s_out_valid), 64'(0));
      check("rst_async_data",  s_out_data, 64'(0));
      check("rst_async_sel",   64'(s_out_sel), 64'(0));
      check("rst_async_ready", 64'(s_in_ready), 64'(0));
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      #1;
      check("rst_first_grant", 64'(s_in_ready), 64'(4'b0001));
      push(0, 64'hA0);
      drive(4'b0000, 1'b1, 4'b0000, "rst_drain");
      @(posedge clk);
      #1;
      use_prio = 1'b1;

      // Fixed priority: channel 1 wins every cycle, 2 and 3 starve.
      for (int k = 0; k < 4; k++) begin
         drive(4'b1110, 1'b1, 4'b0010, "prio_ready");
         push(1, 64'hA1);
      end
      drive(4'b1001, 1'b1, 4'b0001, "prio_low_wins");
      push(0, 64'hA0);
      drive(4'b0000, 1'b1, 4'b0000, "prio_drain");
      @(posedge clk);
      @(posedge clk);
      #1;
      check("sb_drained", 64'(sb_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
